// File: rtl/emul_acq_pkg.sv
// Shared definitions for the emulator acquisition controller: FSM states and default sizes.
package emul_acq_pkg;

    localparam int DEFAULT_WIDTH      = 16;
    localparam int DEFAULT_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } acqState_e;

endpackage

// File: rtl/emul_acq_fifo.sv
// Synchronous output FIFO with flush; a write into a full FIFO is accepted when a read
// happens on the same edge.
module emul_acq_fifo #(
    parameter int DWIDTH = 17,
    parameter int DEPTH  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_wr_en,
    input  logic [DWIDTH-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DWIDTH-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wrPtr;
    logic [AW:0]       r_rdPtr;
    logic              w_doRead;
    logic              w_doWrite;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign o_empty   = (r_wrPtr == r_rdPtr);
    assign o_full    = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_doRead  = i_rd_en && !o_empty && !i_flush;
    assign w_doWrite = i_wr_en && !i_flush && (!o_full || w_doRead);
    assign o_rd_data = r_mem[r_rdPtr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_doWrite) begin
            r_mem[r_wrPtr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doWrite) r_wrPtr <= r_wrPtr + PTR_ONE;
            if (w_doRead)  r_rdPtr <= r_rdPtr + PTR_ONE;
        end
    end

endmodule

// File: rtl/emul_acq_ctrl.sv
// Acquisition controller: drives an emulator, buffers its strobed samples into a stream.
// Optional EMUL_ACQ_HDR_EN prefixes each frame with a frame-counter header word.
module emul_acq_ctrl
    import emul_acq_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [WIDTH-1:0] i_frame_len,
    input  logic [WIDTH-1:0] i_period,
    input  logic [WIDTH-1:0] i_link,
    input  logic             i_strobe,
    output logic             o_emu_valid,
    output logic [WIDTH-1:0] o_emu_r,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_out_last,
    output logic             o_busy,
    output logic             o_overflow,
    output logic             o_aborted
);

    acqState_e        r_state;
    acqState_e        w_nextState;
    logic [WIDTH-1:0] r_frameLen;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_count;
    logic             r_emuValid;
    logic             r_overflow;
    logic             r_aborted;

    logic             w_accept;
    logic             w_abort;
    logic             w_sample;
    logic [WIDTH-1:0] w_countInc;
    logic             w_isLast;
    logic             w_drop;
    logic             w_fifoWrEn;
    logic [WIDTH:0]   w_fifoWrData;
    logic [WIDTH:0]   w_fifoRdData;
    logic             w_fifoFull;
    logic             w_fifoEmpty;

    // Stop always beats a simultaneous start; a zero-length start is never accepted.
    assign w_accept   = (r_state == IDLE) && i_start && !i_stop && (i_frame_len != '0);
    assign w_abort    = i_stop && ((r_state == RUN) || (r_state == DRAIN));
    assign w_sample   = (r_state == RUN) && i_strobe && !i_stop;
    assign w_countInc = r_count + WIDTH'(1);
    assign w_isLast   = (w_countInc == r_frameLen);
    assign w_drop     = w_sample && w_fifoFull && !i_out_ready;

`ifdef EMUL_ACQ_HDR_EN
    logic [WIDTH-1:0] r_frameCnt;

    // Header goes in on the accepting edge, while the FIFO is known to be empty.
    assign w_fifoWrEn   = w_sample || w_accept;
    assign w_fifoWrData = w_accept ? {1'b0, r_frameCnt} : {w_isLast, i_link};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frameCnt <= '0;
        end else if (r_state == DONE) begin
            r_frameCnt <= r_frameCnt + WIDTH'(1);
        end
    end
`else
    assign w_fifoWrEn   = w_sample;
    assign w_fifoWrData = {w_isLast, i_link};
`endif

    emul_acq_fifo #(
        .DWIDTH (WIDTH + 1),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_flush   (w_abort),
        .i_wr_en   (w_fifoWrEn),
        .i_wr_data (w_fifoWrData),
        .i_rd_en   (i_out_ready),
        .o_rd_data (w_fifoRdData),
        .o_full    (w_fifoFull),
        .o_empty   (w_fifoEmpty)
    );

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_nextState = RUN;
            RUN: begin
                if (w_abort)                   w_nextState = IDLE;
                else if (w_sample && w_isLast) w_nextState = DRAIN;
            end
            DRAIN: begin
                if (w_abort)          w_nextState = IDLE;
                else if (w_fifoEmpty) w_nextState = DONE;
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // A dropped sample still advances the count so the frame ends on time.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_frameLen <= '0;
            r_period   <= '0;
            r_count    <= '0;
            r_emuValid <= 1'b0;
            r_overflow <= 1'b0;
            r_aborted  <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_emuValid <= (w_nextState == RUN);
            r_aborted  <= w_abort;
            if (w_accept) begin
                r_frameLen <= i_frame_len;
                r_period   <= i_period;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_sample) r_count    <= w_countInc;
                if (w_drop)   r_overflow <= 1'b1;
            end
        end
    end

    assign o_emu_valid = r_emuValid;
    assign o_emu_r     = r_period;
    assign o_out_valid = !w_fifoEmpty;
    assign o_out_data  = w_fifoEmpty ? '0 : w_fifoRdData[WIDTH-1:0];
    assign o_out_last  = !w_fifoEmpty && w_fifoRdData[WIDTH];
    assign o_busy      = (r_state != IDLE);
    assign o_overflow  = r_overflow;
    assign o_aborted   = r_aborted;

endmodule

// File: tb/tb_emul_acq_ctrl.sv
// Randomised self-checking bench for emul_acq_ctrl with a queue-based stream model.
// Follows EMUL_ACQ_HDR_EN so the model expects header words when the feature is built in.
module tb_emul_acq_ctrl;

    localparam int W     = 16;
    localparam int DEPTH = 8;
`ifdef EMUL_ACQ_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [W-1:0] frameLen = '0;
    logic [W-1:0] period = '0;
    logic [W-1:0] link = '0;
    logic         strobe = 1'b0;
    logic         outReady = 1'b0;
    logic         emuValid;
    logic [W-1:0] emuR;
    logic [W-1:0] outData;
    logic         outValid;
    logic         outLast;
    logic         busy;
    logic         overflow;
    logic         aborted;

    int           nChecks = 0;
    int           nFails = 0;
    logic [W:0]   expQ[$];
    logic         modelOvf = 1'b0;
    int unsigned  frameCnt = 0;

    always #5 clk = ~clk;

    emul_acq_ctrl #(.WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_stop      (stop),
        .i_frame_len (frameLen),
        .i_period    (period),
        .i_link      (link),
        .i_strobe    (strobe),
        .o_emu_valid (emuValid),
        .o_emu_r     (emuR),
        .o_out_data  (outData),
        .o_out_valid (outValid),
        .i_out_ready (outReady),
        .o_out_last  (outLast),
        .o_busy      (busy),
        .o_overflow  (overflow),
        .o_aborted   (aborted)
    );

    // One frame: emulator strobes every per+1 cycles while the model says RUN; the sink
    // accepts with probability readyPct, or (holdCycles>0) stalls until holdCycles after the run.
    task automatic run_frame(input int len, input int per, input int readyPct, input int holdCycles,
                             input int stopAt, input bit extraStart, output int rxWords, output bit sawLast);
        int         sent = 0;
        int         phase = 0;
        int         hold = 0;
        int         budget = 0;
        bit         modelRun;
        bit         extraDone = 0;
        bit         stopNow;
        logic [W:0] exp;
        rxWords = 0;
        sawLast = 0;
        frameLen = W'(len);
        period = W'(per);
        start = 1'b1;
        stop = 1'b0;
        strobe = 1'b0;
        outReady = 1'b0;
        expQ.delete();
        modelOvf = 1'b0;
        if (HDR != 0) expQ.push_back({1'b0, W'(frameCnt)});
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        frameLen = W'($urandom);
        period = W'($urandom);
        modelRun = 1'b1;
        nChecks++;
        if (emuR !== W'(per)) begin
            nFails++; $display("[TB] FAIL emu_r: got %0h expected %0h", emuR, W'(per));
        end
        forever begin
            nChecks++;
            if (emuValid !== modelRun) begin
                nFails++; $display("[TB] FAIL emu_valid: got %b expected %b", emuValid, modelRun);
            end
            nChecks++;
            if (busy !== 1'b1) begin
                nFails++; $display("[TB] FAIL busy_in_frame: got %b expected 1", busy);
            end
            nChecks++;
            if (overflow !== modelOvf) begin
                nFails++; $display("[TB] FAIL overflow: got %b expected %b", overflow, modelOvf);
            end
            nChecks++;
            if (outValid !== (expQ.size() != 0)) begin
                nFails++; $display("[TB] FAIL out_valid: got %b expected %b", outValid, expQ.size() != 0);
            end
            nChecks++;
            if (aborted !== 1'b0) begin
                nFails++; $display("[TB] FAIL aborted_in_frame: got %b expected 0", aborted);
            end
            if (!modelRun && expQ.size() == 0) break;
            if (budget++ > 3000) begin
                nFails++; $display("[TB] FAIL frame_timeout: got busy=%b expected frame end", busy);
                return;
            end
            if (modelRun) begin
                strobe = (phase == per);
                phase = (phase == per) ? 0 : phase + 1;
            end else begin
                strobe = 1'($urandom);
            end
            link = W'($urandom);
            if (holdCycles > 0) begin
                outReady = !modelRun && (hold >= holdCycles);
                if (!modelRun) hold++;
            end else begin
                outReady = ($urandom_range(99) < readyPct);
            end
            stopNow = (stopAt != 0) && modelRun && strobe && (sent + 1 == stopAt);
            stop = stopNow;
            start = 1'b0;
            if (extraStart && !extraDone && modelRun && sent >= 1 && !stopNow) begin
                start = 1'b1;
                frameLen = W'($urandom_range(50, 1));
                extraDone = 1;
            end
            #1;
            if (outValid && outReady) begin
                rxWords++;
                sawLast |= outLast;
                nChecks++;
                if (expQ.size() == 0) begin
                    nFails++; $display("[TB] FAIL stream_word: got %0h expected no word", {outLast, outData});
                end else begin
                    exp = expQ.pop_front();
                    if ({outLast, outData} !== exp) begin
                        nFails++; $display("[TB] FAIL stream_word: got %0h expected %0h", {outLast, outData}, exp);
                    end
                end
            end
            if (stopNow) begin
                expQ.delete();
                @(posedge clk); @(negedge clk);
                stop = 1'b0;
                strobe = 1'b0;
                start = 1'b0;
                nChecks++;
                if ({aborted, outValid, busy, emuValid} !== 4'b1000) begin
                    nFails++; $display("[TB] FAIL abort_edge: got %b expected 1000", {aborted, outValid, busy, emuValid});
                end
                @(posedge clk); @(negedge clk);
                nChecks++;
                if (aborted !== 1'b0) begin
                    nFails++; $display("[TB] FAIL abort_pulse_len: got %b expected 0", aborted);
                end
                return;
            end
            if (modelRun && strobe) begin
                sent++;
                if (expQ.size() < DEPTH) expQ.push_back({sent == len, link});
                else modelOvf = 1'b1;
                if (sent == len) modelRun = 1'b0;
            end
            @(posedge clk); @(negedge clk);
        end
        start = 1'b0;
        strobe = 1'($urandom);
        outReady = 1'($urandom);
        @(posedge clk); @(negedge clk);
        nChecks++;
        if ({busy, outValid, emuValid} !== 3'b100) begin
            nFails++; $display("[TB] FAIL done_state: got %b expected 100", {busy, outValid, emuValid});
        end
        strobe = 1'b0;
        @(posedge clk); @(negedge clk);
        nChecks++;
        if ({busy, aborted} !== 2'b00) begin
            nFails++; $display("[TB] FAIL back_to_idle: got %b expected 00", {busy, aborted});
        end
        frameCnt++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        nChecks++;
        if ({emuValid, outValid, outLast, busy, overflow, aborted, emuR, outData} !== '0) begin
            nFails++; $display("[TB] FAIL reset_outputs: got %0h expected 0",
                               {emuValid, outValid, outLast, busy, overflow, aborted, emuR, outData});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        nChecks++;
        if ({busy, outValid, emuValid} !== 3'b000) begin
            nFails++; $display("[TB] FAIL after_reset: got %b expected 000", {busy, outValid, emuValid});
        end
        frameCnt = 0;
    endtask

    task automatic test_basic;
        int rx;
        bit last;
        run_frame(4, 3, 100, 0, 0, 0, rx, last);
        nChecks++;
        if (rx !== 4 + HDR || last !== 1'b1) begin
            nFails++; $display("[TB] FAIL basic_frame: got words=%0d last=%b expected words=%0d last=1", rx, last, 4 + HDR);
        end
        for (int i = 0; i < 4; i++) begin
            run_frame($urandom_range(12, 1), $urandom_range(3, 0), $urandom_range(100, 30), 0, 0, 0, rx, last);
        end
    endtask

    task automatic test_overflow;
        int rx;
        bit last;
        run_frame(10, 0, 0, 5, 0, 0, rx, last);
        nChecks++;
        if (rx !== DEPTH || last !== 1'b0 || overflow !== 1'b1) begin
            nFails++; $display("[TB] FAIL overflow_frame: got words=%0d last=%b ovf=%b expected words=%0d last=0 ovf=1",
                               rx, last, overflow, DEPTH);
        end
    endtask

    task automatic test_abort;
        int rx;
        bit last;
        run_frame(6, 1, 60, 0, 3, 0, rx, last);
        run_frame(5, 0, 100, 0, 0, 0, rx, last);
        nChecks++;
        if (rx !== 5 + HDR || last !== 1'b1) begin
            nFails++; $display("[TB] FAIL after_abort: got words=%0d last=%b expected words=%0d last=1", rx, last, 5 + HDR);
        end
    endtask

    task automatic test_ignored;
        int rx;
        bit last;
        @(negedge clk);
        start = 1'b1; stop = 1'b1; frameLen = W'(5);
        @(posedge clk); @(negedge clk);
        start = 1'b0; stop = 1'b0;
        nChecks++;
        if ({busy, emuValid, aborted} !== 3'b000) begin
            nFails++; $display("[TB] FAIL start_stop_idle: got %b expected 000", {busy, emuValid, aborted});
        end
        start = 1'b1; frameLen = '0;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        nChecks++;
        if ({busy, emuValid} !== 2'b00) begin
            nFails++; $display("[TB] FAIL zero_len_start: got %b expected 00", {busy, emuValid});
        end
        run_frame(8, 1, 70, 0, 0, 1, rx, last);
    endtask

    task automatic test_reset_drain;
        @(negedge clk);
        frameLen = W'(3); period = '0; start = 1'b1; outReady = 1'b0; strobe = 1'b0;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            strobe = 1'b1; link = W'($urandom);
            @(posedge clk); @(negedge clk);
        end
        strobe = 1'b0;
        @(posedge clk); @(negedge clk);
        nChecks++;
        if ({busy, outValid, emuValid} !== 3'b110) begin
            nFails++; $display("[TB] FAIL drain_before_reset: got %b expected 110", {busy, outValid, emuValid});
        end
        #2 rst_n = 1'b0;
        #1;
        nChecks++;
        if ({emuValid, outValid, outLast, busy, overflow, aborted, emuR, outData} !== '0) begin
            nFails++; $display("[TB] FAIL reset_mid_drain: got %0h expected 0",
                               {emuValid, outValid, outLast, busy, overflow, aborted, emuR, outData});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            nChecks++;
            if ({aborted, busy, outValid} !== 3'b000) begin
                nFails++; $display("[TB] FAIL post_reset_quiet: got %b expected 000", {aborted, busy, outValid});
            end
        end
        expQ.delete();
        frameCnt = 0;
    endtask

    task automatic test_back_to_back;
        int rx;
        bit last;
        for (int i = 0; i < 3; i++) begin
            run_frame(2, 0, $urandom_range(100, 50), 0, 0, 0, rx, last);
            nChecks++;
            if (rx !== 2 + HDR || last !== 1'b1) begin
                nFails++; $display("[TB] FAIL b2b_frame: got words=%0d last=%b expected words=%0d last=1", rx, last, 2 + HDR);
            end
        end
        run_frame(4, 0, 100, 0, 2, 0, rx, last);
        run_frame(2, 1, 100, 0, 0, 0, rx, last);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_abort();
        test_ignored();
        test_reset_drain();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/emul_acq_ctrl.md
EMUL_ACQ_CTRL -- requirements
Module: emul_acq_ctrl

Interface
REQ-001 Parameter WIDTH, default 16: sample, period and frame-length width.
REQ-002 Parameter FIFO_DEPTH, default 8: output buffer entries, power of two, at least 2.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to begin a frame.
REQ-006 stop  in  1  one-cycle abort request.
REQ-007 frame_len  in  WIDTH  samples per frame; latched on an accepted start.
REQ-008 period  in  WIDTH  strobe period for the emulator; latched on an accepted start.
REQ-009 link  in  WIDTH  emulator sample value.
REQ-010 strobe  in  1  emulator sample strobe.
REQ-011 emu_valid  out  1  enable to the emulator's valid input.
REQ-012 emu_r  out  WIDTH  latched period to the emulator's r input.
REQ-013 out_data  out  WIDTH  stream data.
REQ-014 out_valid / out_ready  out / in  1  stream handshake; a transfer occurs when both are high.
REQ-015 out_last  out  1  qualifies the final word of a complete frame.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 overflow  out  1  sticky dropped-sample flag.
REQ-018 aborted  out  1  one-cycle pulse when an abort completes.

Function
REQ-019 The FSM SHALL have four states: IDLE, RUN, DRAIN and DONE.
REQ-020 In IDLE, a start with frame_len != 0 SHALL latch frame_len and period, clear overflow and the sample count, and enter RUN on the next edge.
REQ-021 A start with frame_len == 0 SHALL be ignored.
REQ-022 A start in any state other than IDLE SHALL be ignored.
REQ-023 emu_valid SHALL be registered high in RUN only, so the first cycle in RUN has emu_valid=1.
REQ-024 emu_r SHALL hold the latched period in all states.
REQ-025 In RUN, each cycle with strobe=1 SHALL write {last, link} into the FIFO on that edge (one-cycle capture latency) and increment the sample count.
REQ-026 last SHALL be 1 exactly when the incremented count equals frame_len.
REQ-027 When the count reaches frame_len, the FSM SHALL enter DRAIN on the same edge; emu_valid SHALL be 0 from the next cycle.
REQ-028 A strobe while the FIFO is full SHALL drop the sample, set overflow and still increment the count, so frame length is preserved in time.
REQ-029 If the dropped sample is the last one, out_last SHALL never assert for that frame, and DRAIN SHALL exit on FIFO empty.
REQ-030 A FIFO write and read in the same cycle while full SHALL be accepted.
REQ-031 DRAIN SHALL move to DONE when the FIFO is empty; DONE SHALL last one cycle, then return to IDLE.
REQ-032 Strobes outside RUN SHALL be ignored.
REQ-033 A stop in RUN or DRAIN SHALL flush the FIFO, drop emu_valid and out_valid on the next edge, pulse aborted for one cycle and enter IDLE.
REQ-034 If start and stop are asserted in the same cycle, stop SHALL win.
REQ-035 out_valid SHALL equal FIFO not-empty; out_data and out_last SHALL be stable while out_valid=1 and out_ready=0.
REQ-036 Count arithmetic SHALL be WIDTH-bit unsigned, with no wrap possible because the count is at most frame_len.

Reset
REQ-037 On reset low, the block SHALL asynchronously enter IDLE with the FIFO empty.
REQ-038 During reset, emu_valid, out_valid, out_last, busy, overflow and aborted SHALL be 0, and emu_r, out_data and the latched registers SHALL be 0.
REQ-039 Reset mid-frame SHALL discard all buffered data without asserting aborted.

Configuration
REQ-040 With EMUL_ACQ_HDR_EN defined, on entry to RUN a header word equal to a WIDTH-bit frame counter SHALL be written to the FIFO before any sample, with last=0.
REQ-041 The frame counter SHALL reset to 0, increment on DONE (not on abort) and wrap modulo 2^WIDTH.
REQ-042 With EMUL_ACQ_HDR_EN undefined, no header word and no frame counter logic SHALL exist; the stream carries samples only.

Structure
REQ-043 Package emul_acq_pkg SHALL hold the state enumeration and the default WIDTH and FIFO_DEPTH constants.
REQ-044 The FIFO SHALL be the sub-module emul_acq_fifo: synchronous, WIDTH+1 bits wide, with flush, full and empty.

Verification
REQ-045 frame_len=4, period=3, out_ready=1: emu_valid is high in RUN, 4 words equal link at each strobe are delivered, out_last on word 4, busy falls 1 cycle after the FIFO empties.
REQ-046 FIFO_DEPTH=8, out_ready=0, frame_len=10, period=0: 8 words are buffered, overflow=1, 2 samples are dropped, no out_last, the FSM stays in DRAIN until out_ready releases 8 words, then reaches IDLE.
REQ-047 stop asserted on the 3rd strobe of frame_len=6: aborted pulses once, out_valid=0 on the next cycle, the FSM is in IDLE, and a following start runs normally.
REQ-048 start and stop in the same cycle in IDLE: no state change; start with frame_len=0: no state change; start during RUN: ignored.
REQ-049 reset pulsed low mid-DRAIN with 3 words buffered: all outputs are 0 immediately, and no aborted pulse occurs.
REQ-050 EMUL_ACQ_HDR_EN defined, two frames of frame_len=2: streams are {0,s,s(last)} then {1,s,s(last)}; after an aborted frame the next header is unchanged.
